bcd_mod_counter: RTL and testbench

- Two-digit BCD up/down counter with a parameterised modulus: 100 gives 00..99, 60 gives 00..59.
- It is the generic replacement for the per-modulus decimal registers used in the stopwatch/clock datapath (centiseconds, seconds, minutes, hours).
- Stages cascade on a single clock: one stage's cout drives the next stage's add or sub.

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_mod_counter.sv | 82 ++++++++
 tb/tb_bcd_mod_counter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and single-digit step helpers
// used by every decimal register in the stopwatch/clock datapath.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Returns {carry, next_digit}; carry marks that the digit sat at its max and wrapped to zero.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t d, input bcd_digit_t max_val);
    logic [4:0] r;
    if (d >= max_val) r = {1'b1, BCD_ZERO};
    else              r = {1'b0, d + 4'd1};
    return r;
  endfunction

  // Returns {borrow, next_digit}; borrow marks that the digit sat at zero and wrapped to max.
  function automatic logic [4:0] bcd_dec(input bcd_digit_t d, input bcd_digit_t max_val);
    logic [4:0] r;
    if (d == BCD_ZERO) r = {1'b1, max_val};
    else               r = {1'b0, d - 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with enable, up/down direction, a programmable max value
// and a synchronous load that takes priority over counting.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  bcd_digit_t max_val,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_zero
);

  bcd_digit_t next_up;
  bcd_digit_t next_dn;

  // The carry/borrow bits double as terminal flags for the parent.
  assign {at_max,  next_up} = bcd_inc(digit, max_val);
  assign {at_zero, next_dn} = bcd_dec(digit, max_val);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= load_val;
    end else if (en) begin
      digit <= up ? next_up : next_dn;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter with range 0..MODULUS-1 and a combinational
// carry/borrow output that enables the next stage on the same clock edge.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int MODULUS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add,
  input  logic       sub,
  input  logic       hold,
  output logic [3:0] low,
  output logic [3:0] high,
  output logic       cout
);

  localparam int         LAST       = MODULUS - 1;
  localparam bcd_digit_t TENS_LAST  = bcd_digit_t'(LAST / 10);
  localparam bcd_digit_t UNITS_LAST = bcd_digit_t'(LAST % 10);

  logic       inc;
  logic       dec;
  logic       low_max;
  logic       low_zero;
  logic       high_max;
  logic       high_zero;
  logic       at_last;
  logic       at_first;
  logic       wrap_up;
  logic       wrap_dn;
  logic       units_en;
  logic       tens_en;
  bcd_digit_t units_load_val;
  bcd_digit_t tens_load_val;

  assign inc = ~hold & add & ~sub;
  assign dec = ~hold & sub & ~add;

  // Terminal value is checked on both digits because the units digit of
  // MODULUS-1 need not be 9 (e.g. 44 for MODULUS 45).
  assign at_last  = high_max & (low == UNITS_LAST);
  assign at_first = high_zero & low_zero;

  assign wrap_up = inc & at_last;
  assign wrap_dn = dec & at_first;
  assign cout    = wrap_up | wrap_dn;

  assign units_en = inc | dec;
  assign tens_en  = (inc & low_max) | (dec & low_zero);

  // Wraps are loaded directly so both digits land on 00 or MODULUS-1 together.
  assign units_load_val = wrap_dn ? UNITS_LAST : BCD_ZERO;
  assign tens_load_val  = wrap_dn ? TENS_LAST  : BCD_ZERO;

  bcd_digit u_units (
    .clk      (clk),
    .rst      (rst),
    .en       (units_en),
    .up       (inc),
    .load     (cout),
    .load_val (units_load_val),
    .max_val  (BCD_MAX),
    .digit    (low),
    .at_max   (low_max),
    .at_zero  (low_zero)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst      (rst),
    .en       (tens_en),
    .up       (inc),
    .load     (cout),
    .load_val (tens_load_val),
    .max_val  (TENS_LAST),
    .digit    (high),
    .at_max   (high_max),
    .at_zero  (high_zero)
  );

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench: standalone MODULUS 100 and 60 counters against an
// arithmetic model, plus a 100->60->60 cascade checked against a total count.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, add, sub, hold, casc_add;
  logic [3:0] low100, high100, low60, high60;
  logic cout100, cout60;
  logic [3:0] cl0, ch0, cl1, ch1, cl2, ch2;
  logic cc0, cc1, cc2;

  int checks = 0;
  int errors = 0;
  int m100 = 0;
  int m60 = 0;
  int n = 0;

  bcd_mod_counter #(.MODULUS(100)) u100 (
    .clk(clk), .rst(rst), .add(add), .sub(sub), .hold(hold),
    .low(low100), .high(high100), .cout(cout100)
  );

  bcd_mod_counter #(.MODULUS(60)) u60 (
    .clk(clk), .rst(rst), .add(add), .sub(sub), .hold(hold),
    .low(low60), .high(high60), .cout(cout60)
  );

  bcd_mod_counter #(.MODULUS(100)) c0 (
    .clk(clk), .rst(rst), .add(casc_add), .sub(1'b0), .hold(1'b0),
    .low(cl0), .high(ch0), .cout(cc0)
  );

  bcd_mod_counter #(.MODULUS(60)) c1 (
    .clk(clk), .rst(rst), .add(cc0), .sub(1'b0), .hold(1'b0),
    .low(cl1), .high(ch1), .cout(cc1)
  );

  bcd_mod_counter #(.MODULUS(60)) c2 (
    .clk(clk), .rst(rst), .add(cc1), .sub(1'b0), .hold(1'b0),
    .low(cl2), .high(ch2), .cout(cc2)
  );

  function automatic int model_step(int v, int m, bit a, bit s, bit h);
    if (h || (a && s)) return v;
    if (a) return (v == m - 1) ? 0 : v + 1;
    if (s) return (v == 0) ? m - 1 : v - 1;
    return v;
  endfunction

  function automatic logic [31:0] model_cout(int v, int m, bit a, bit s, bit h);
    if (h) return 0;
    if (a && !s && v == m - 1) return 1;
    if (s && !a && v == 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] bcd8(int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(string tag);
    check({tag, "_v100"}, 32'({high100, low100}), bcd8(m100));
    check({tag, "_v60"},  32'({high60, low60}),   bcd8(m60));
  endtask

  // Drives one step, checks same-cycle cout, then checks the post-edge value.
  task automatic apply_stimulus(bit a, bit s, bit h, string tag);
    add = a; sub = s; hold = h;
    #1;
    check({tag, "_cout100"}, 32'(cout100), model_cout(m100, 100, a, s, h));
    check({tag, "_cout60"},  32'(cout60),  model_cout(m60, 60, a, s, h));
    @(posedge clk);
    m100 = model_step(m100, 100, a, s, h);
    m60  = model_step(m60, 60, a, s, h);
    #1;
    check_output(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b0; add = 1'b0; sub = 1'b0; hold = 1'b0; casc_add = 1'b0;
    #1;
    m100 = 0; m60 = 0; n = 0;
    check_output(tag);
    check({tag, "_cout100"}, 32'(cout100), 0);
    check({tag, "_cout60"},  32'(cout60),  0);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; add = 1'b0; sub = 1'b0; hold = 1'b0; casc_add = 1'b0;
    @(negedge clk);
    do_reset("por");

    // Reach 37, then reset asynchronously mid-cycle and resume.
    for (int i = 0; i < 37; i++) apply_stimulus(1, 0, 0, "to37");
    do_reset("mid_rst");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, "post_rst");
    check("v03", 32'({high100, low100}), 32'h03);

    // Full MODULUS-60 up cycle; the 100 counter passes 09->10, 19->20 on the way.
    do_reset("up_rst");
    for (int i = 0; i < 60; i++) apply_stimulus(1, 0, 0, "up60");
    check("wrap60", 32'({high60, low60}), 32'h00);
    for (int i = 0; i < 40; i++) apply_stimulus(1, 0, 0, "up100");
    check("wrap100", 32'({high100, low100}), 32'h00);

    // Down wrap from 00 and borrow from 10.
    do_reset("dn_rst");
    apply_stimulus(0, 1, 0, "dn_wrap");
    check("dn59", 32'({high60, low60}), 32'h59);
    do_reset("dn10_rst");
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, "to10");
    apply_stimulus(0, 1, 0, "dn10");
    check("dn09", 32'({high60, low60}), 32'h09);

    // Hold at 59 with add, and cancelling add+sub at 42.
    do_reset("hold_rst");
    apply_stimulus(0, 1, 0, "to59");
    apply_stimulus(1, 0, 1, "hold59");
    check("hold_keeps59", 32'({high60, low60}), 32'h59);
    do_reset("conf_rst");
    for (int i = 0; i < 42; i++) apply_stimulus(1, 0, 0, "to42");
    apply_stimulus(1, 1, 0, "conf42");
    check("conf_keeps42", 32'({high60, low60}), 32'h42);

    // Random mix against the model.
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 7) == 0), "rand");
    end

    // Cascade: 6000 adds into the 100->60->60 chain.
    do_reset("casc_rst");
    for (int i = 0; i < 6000; i++) begin
      casc_add = 1'b1;
      #1;
      check("casc_cc0", 32'(cc0), 32'(n % 100 == 99));
      check("casc_cc1", 32'(cc1), 32'((n % 6000) == 5999));
      check("casc_cc2", 32'(cc2), 0);
      @(posedge clk);
      n++;
      #1;
      check("casc_s0", 32'({ch0, cl0}), bcd8(n % 100));
      check("casc_s1", 32'({ch1, cl1}), bcd8((n / 100) % 60));
      check("casc_s2", 32'({ch2, cl2}), bcd8((n / 6000) % 60));
      @(negedge clk);
    end
    casc_add = 1'b0;
    check("casc_final", 32'({ch2, cl2, ch1, cl1, ch0, cl0}), 32'h010000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
